// File: rtl/rapcore_wb_spi_pkg.sv
// Shared constants for the rapcore Wishbone-to-SPI bridge: register map,
// CTRL/STATUS bit positions and the shift-engine state encoding.
package rapcore_wb_spi_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_RXDATA = 4'hC;

    localparam int CTRL_HOLD  = 8;
    localparam int CTRL_ABORT = 9;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_RXVALID = 1;
    localparam int STAT_OVERRUN = 2;

    localparam logic [7:0] DIV_RESET_DEF = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/rapcore_spi_shift_engine.sv
// SPI mode-0 master word engine: half-period timer, toggle counter and
// full-duplex MSB-first shifters, with optional CS hold between words.
module rapcore_spi_shift_engine
    import rapcore_wb_spi_pkg::*;
#(
    parameter int         WORD_BITS = 32,
    parameter logic [7:0] DIV_RESET = DIV_RESET_DEF
) (
    input  logic                 gclk,
    input  logic                 grst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    input  logic [7:0]           div,
    input  logic [WORD_BITS-1:0] txword,
    input  logic                 cipo,
    output logic                 sck,
    output logic                 cs,
    output logic                 copi,
    output logic [WORD_BITS-1:0] rxword,
    output logic                 done,
    output logic                 busy
);

    localparam int             TW       = $clog2(2 * WORD_BITS);
    localparam logic [TW-1:0]  TOG_LAST = TW'(2 * WORD_BITS - 1);

    spi_state_e           state_q, state_d;
    logic [7:0]           hp_cnt, cur_div;
    logic [TW-1:0]        tog_cnt;
    logic [WORD_BITS-1:0] tx_sh, rx_sh;
    logic                 hp_end, rise, fall;

    // div is re-sampled only at half-period boundaries so a mid-word
    // CTRL write never truncates the half-period in flight
    assign hp_end = (hp_cnt == cur_div);
    assign rxword = rx_sh;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start)            state_d = cs ? ST_SETUP : ST_SHIFT;
                    else if (!cs && !hold) state_d = ST_GAP;
                end
                ST_SETUP: if (hp_end) state_d = ST_SHIFT;
                ST_SHIFT: if (hp_end && tog_cnt == TOG_LAST) state_d = ST_TRAIL;
                ST_TRAIL: if (hp_end) state_d = hold ? ST_IDLE : ST_GAP;
                ST_GAP:   if (hp_end) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The first rising edge is issued as SETUP expires, so a chained word
    // entering SHIFT directly sees the same H-long low phase first.
    always_comb begin
        busy = (state_q != ST_IDLE);
        rise = 1'b0;
        fall = 1'b0;
        done = 1'b0;
        if (!abort) begin
            case (state_q)
                ST_SETUP: rise = hp_end;
                ST_SHIFT: begin
                    rise = hp_end & ~sck;
                    fall = hp_end &  sck;
                end
                ST_TRAIL: done = hp_end;
                default: ;
            endcase
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            sck     <= 1'b0;
            cs      <= 1'b1;
            copi    <= 1'b0;
            hp_cnt  <= '0;
            cur_div <= DIV_RESET;
            tog_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
        end else if (abort) begin
            sck    <= 1'b0;
            cs     <= 1'b1;
            copi   <= 1'b0;
            hp_cnt <= '0;
        end else begin
            if (state_q == ST_IDLE || hp_end) begin
                hp_cnt  <= '0;
                cur_div <= div;
            end else begin
                hp_cnt <= hp_cnt + 8'd1;
            end
            if (state_q == ST_IDLE) begin
                if (start) begin
                    cs      <= 1'b0;
                    sck     <= 1'b0;
                    copi    <= txword[WORD_BITS-1];
                    tx_sh   <= txword;
                    tog_cnt <= '0;
                end else if (!cs && !hold) begin
                    cs <= 1'b1;
                end
            end
            if (rise) begin
                sck     <= 1'b1;
                rx_sh   <= {rx_sh[WORD_BITS-2:0], cipo};
                tog_cnt <= tog_cnt + 1'b1;
            end
            if (fall) begin
                sck     <= 1'b0;
                tx_sh   <= {tx_sh[WORD_BITS-2:0], 1'b0};
                copi    <= tx_sh[WORD_BITS-2];
                tog_cnt <= tog_cnt + 1'b1;
            end
            if (done && !hold) cs <= 1'b1;
        end
    end

endmodule

// File: rtl/rapcore_wb_spi_bridge.sv
// Wishbone slave exposing CTRL/STATUS/TXDATA/RXDATA and driving the rapcore
// SPI command port through the shift engine.
module rapcore_wb_spi_bridge
    import rapcore_wb_spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  DIV_RESET = DIV_RESET_DEF,
    parameter int          WORD_BITS = 32
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        SCK,
    output logic        CS,
    output logic        COPI,
    input  logic        CIPO,
    output logic        busy
);

    logic                 valid, acc, wr, rd;
    logic [3:0]           off;
    logic [7:0]           div_q;
    logic                 hold_q, rx_valid_q, overrun_q;
    logic [31:0]          rx_data_q, rd_mux;
    logic                 start, abort, done, eng_busy;
    logic [WORD_BITS-1:0] rxword;
    logic                 sel_unused;

    assign sel_unused = &{1'b0, wbs_sel_i[3:2]};

    // acc excludes the ack cycle so a held strobe never gets back-to-back acks
    assign valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc   = valid & ~wbs_ack_o;
    assign off   = wbs_adr_i[3:0];
    assign wr    = acc & wbs_we_i;
    assign rd    = acc & ~wbs_we_i;
    assign abort = wr && (off == OFF_CTRL) && wbs_sel_i[1] && wbs_dat_i[CTRL_ABORT];
    assign start = wr && (off == OFF_TXDATA) && !eng_busy;
    assign busy  = eng_busy;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL: begin
                rd_mux[7:0]       = div_q;
                rd_mux[CTRL_HOLD] = hold_q;
            end
            OFF_STATUS: begin
                rd_mux[STAT_BUSY]    = eng_busy;
                rd_mux[STAT_RXVALID] = rx_valid_q;
                rd_mux[STAT_OVERRUN] = overrun_q;
            end
            OFF_RXDATA: rd_mux = rx_data_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            div_q      <= DIV_RESET;
            hold_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= rd ? rd_mux : '0;
            if (wr && off == OFF_CTRL) begin
                if (wbs_sel_i[0]) div_q  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) hold_q <= wbs_dat_i[CTRL_HOLD];
            end
            if (wr && off == OFF_TXDATA && eng_busy)
                overrun_q <= 1'b1;
            else if (wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_OVERRUN])
                overrun_q <= 1'b0;
            // a word completing on the same edge as an RXDATA read stays valid
            if (done) begin
                rx_data_q  <= rxword;
                rx_valid_q <= 1'b1;
            end else if (rd && off == OFF_RXDATA) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    rapcore_spi_shift_engine #(
        .WORD_BITS (WORD_BITS),
        .DIV_RESET (DIV_RESET)
    ) u_engine (
        .gclk   (CLK),
        .grst_n (resetn),
        .start  (start),
        .abort  (abort),
        .hold   (hold_q),
        .div    (div_q),
        .txword (wbs_dat_i),
        .cipo   (CIPO),
        .sck    (SCK),
        .cs     (CS),
        .copi   (COPI),
        .rxword (rxword),
        .done   (done),
        .busy   (eng_busy)
    );

endmodule

// File: tb/tb_rapcore_wb_spi_bridge.sv
// Bench for rapcore_wb_spi_bridge: table-driven single-word transfers with an
// SPI slave model and a COPI scoreboard, plus hold/overrun/abort/reset/bus cases.
module tb_rapcore_wb_spi_bridge;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_TX   = BASE + 32'h8;
    localparam logic [31:0] A_RX   = BASE + 32'hC;

    typedef struct {
        logic [7:0]  div;
        logic [31:0] tx;
        logic [31:0] rx;
        int          lat;
    } vec_t;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        SCK, CS, COPI, busy;
    logic        CIPO = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    rapcore_wb_spi_bridge #(
        .BASE_ADDR (BASE),
        .DIV_RESET (8'd3),
        .WORD_BITS (32)
    ) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .SCK       (SCK),
        .CS        (CS),
        .COPI      (COPI),
        .CIPO      (CIPO),
        .busy      (busy)
    );

    // SPI slave model, sampled on the falling CLK edge away from DUT updates
    logic        sck_prev = 1'b0, cs_prev = 1'b1;
    logic [31:0] slv_out_word = '0;
    logic [31:0] slv_sh = '0, slv_in = '0;
    int          slv_bits = 0, sck_rises = 0, cs_rises = 0, run = 0;
    int          hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          got_rd = 0;

    always @(negedge CLK) begin
        if (!CS && cs_prev) begin
            hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
            slv_sh = slv_out_word;
            CIPO = slv_sh[31];
            slv_bits = 0;
        end
        if (CS && !cs_prev) cs_rises++;
        if (SCK != sck_prev) begin
            if (sck_prev) begin
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
            end else if (slv_bits != 0) begin
                if (run < lo_min) lo_min = run;
                if (run > lo_max) lo_max = run;
            end
            run = 1;
        end else begin
            run++;
        end
        if (SCK && !sck_prev) begin
            slv_in = {slv_in[30:0], COPI};
            sck_rises++;
            slv_bits++;
            if (slv_bits == 32) begin
                got_q.push_back(slv_in);
                slv_bits = 0;
            end
        end
        if (!SCK && sck_prev) begin
            if (slv_bits == 0) slv_sh = slv_out_word;
            else               slv_sh = slv_sh << 1;
            CIPO = slv_sh[31];
        end
        sck_prev = SCK;
        cs_prev = CS;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic ack);
        int n;
        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        n = 0; ack = 1'b0; rdat = '0;
        while (!ack && n < 8) begin
            @(negedge CLK);
            n++;
            if (wbs_ack_o) begin
                ack = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input string name, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        logic [31:0] r;
        logic a;
        wb_xfer(1'b1, adr, dat, sel, r, a);
        chk({name, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic wb_rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic a;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, r, a);
        chk({name, "_ack"}, 32'(a), 32'd1);
        chk(name, r, exp);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic sb_check(input string name);
        int n;
        n = 0;
        while (got_q.size() <= got_rd && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (got_q.size() > got_rd && exp_q.size() > 0) begin
            chk(name, got_q[got_rd], exp_q.pop_front());
            got_rd++;
        end else begin
            chk({name, "_present"}, 32'(got_q.size()), 32'(got_rd + 1));
        end
    endtask

    initial begin
        vec_t        vecs[3];
        logic [31:0] r;
        logic        a;
        int          n, r0, c0, h, acks, run_a, max_a;

        vecs[0] = '{8'd3, 32'hA5C3_0F96, 32'h1234_5678, 264};
        vecs[1] = '{8'd0, 32'h8000_0001, 32'hFFFF_0000, 66};
        vecs[2] = '{8'd1, 32'h0F0F_F0F0, 32'h5A5A_A5A5, 132};

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_cs", 32'(CS), 32'd1);
        chk("rst_sck", 32'(SCK), 32'd0);
        chk("rst_copi", 32'(COPI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        resetn = 1'b1;
        wb_rd_chk("rst_ctrl", A_CTRL, 32'h0000_0003);
        wb_rd_chk("rst_status", A_STAT, 32'h0);

        // single-word transfers from the vector table
        for (int i = 0; i < 3; i++) begin
            h = int'(vecs[i].div) + 1;
            wb_wr($sformatf("v%0d_ctrl", i), A_CTRL, {24'd0, vecs[i].div}, 4'b0011);
            slv_out_word = vecs[i].rx;
            r0 = sck_rises;
            exp_q.push_back(vecs[i].tx);
            wb_wr($sformatf("v%0d_tx", i), A_TX, vecs[i].tx, 4'hF);
            chk($sformatf("v%0d_busy_on_ack", i), 32'(busy), 32'd1);
            wait_idle(n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
            sb_check($sformatf("v%0d_copi", i));
            chk($sformatf("v%0d_rises", i), 32'(sck_rises - r0), 32'd32);
            chk($sformatf("v%0d_hi_min", i), 32'(hi_min), 32'(h));
            chk($sformatf("v%0d_hi_max", i), 32'(hi_max), 32'(h));
            chk($sformatf("v%0d_lo_min", i), 32'(lo_min), 32'(h));
            chk($sformatf("v%0d_lo_max", i), 32'(lo_max), 32'(h));
            chk($sformatf("v%0d_cs_idle", i), 32'(CS), 32'd1);
            wb_rd_chk($sformatf("v%0d_stat_rxv", i), A_STAT, 32'h2);
            wb_rd_chk($sformatf("v%0d_rxdata", i), A_RX, vecs[i].rx);
            wb_rd_chk($sformatf("v%0d_stat_clr", i), A_STAT, 32'h0);
        end

        // hold chaining: two words under one CS low window
        wb_wr("hold_ctrl", A_CTRL, 32'h0000_0103, 4'b0011);
        slv_out_word = 32'hCAFE_F00D;
        r0 = sck_rises;
        c0 = cs_rises;
        exp_q.push_back(32'h1111_2222);
        wb_wr("hold_tx0", A_TX, 32'h1111_2222, 4'hF);
        wait_idle(n);
        chk("hold_latency", 32'(n), 32'd260);
        chk("hold_cs_low_between", 32'(CS), 32'd0);
        exp_q.push_back(32'h3333_4444);
        wb_wr("hold_tx1", A_TX, 32'h3333_4444, 4'hF);
        wait_idle(n);
        chk("hold_idle1", 32'(busy), 32'd0);
        chk("hold_cs_low_after", 32'(CS), 32'd0);
        chk("hold_cs_no_rise", 32'(cs_rises - c0), 32'd0);
        chk("hold_rises", 32'(sck_rises - r0), 32'd64);
        sb_check("hold_copi0");
        sb_check("hold_copi1");
        wb_wr("unhold_ctrl", A_CTRL, 32'h0000_0003, 4'b0011);
        @(negedge CLK);
        chk("unhold_cs_next", 32'(CS), 32'd1);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (CS) n++;
        end
        chk("unhold_cs_high_h", 32'(n), 32'd4);
        wait_idle(n);
        chk("unhold_idle", 32'(busy), 32'd0);
        wb_rd_chk("hold_rxdata", A_RX, 32'hCAFE_F00D);

        // overrun: second TXDATA during busy is acked and dropped
        slv_out_word = 32'h0BAD_BEEF;
        exp_q.push_back(32'h1357_9BDF);
        wb_wr("ovr_tx0", A_TX, 32'h1357_9BDF, 4'hF);
        repeat (20) @(negedge CLK);
        wb_wr("ovr_tx1", A_TX, 32'hFFFF_FFFF, 4'hF);
        wb_rd_chk("ovr_stat_busy", A_STAT, 32'h5);
        wait_idle(n);
        chk("ovr_idle", 32'(busy), 32'd0);
        sb_check("ovr_copi");
        wb_rd_chk("ovr_stat_done", A_STAT, 32'h6);
        wb_wr("ovr_w1c", A_STAT, 32'h0000_0004, 4'b0001);
        wb_rd_chk("ovr_stat_clr", A_STAT, 32'h2);
        wb_rd_chk("ovr_rxdata", A_RX, 32'h0BAD_BEEF);

        // abort after 10 SCK pulses; same write moves div to 5
        wb_wr("abt_tx", A_TX, 32'h0F0F_0F0F, 4'hF);
        r0 = sck_rises;
        n = 0;
        while (sck_rises - r0 < 10 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("abt_reached_10", 32'(sck_rises - r0 >= 10), 32'd1);
        wb_wr("abt_ctrl", A_CTRL, 32'h0000_0205, 4'b0011);
        chk("abt_cs", 32'(CS), 32'd1);
        chk("abt_sck", 32'(SCK), 32'd0);
        chk("abt_copi", 32'(COPI), 32'd0);
        chk("abt_busy", 32'(busy), 32'd0);
        wb_rd_chk("abt_stat", A_STAT, 32'h0);
        wb_rd_chk("abt_ctrl_rd", A_CTRL, 32'h0000_0005);

        // asynchronous reset mid-transfer, asserted between CLK edges
        wb_wr("rst_tx", A_TX, 32'hFFFF_0000, 4'hF);
        r0 = sck_rises;
        n = 0;
        while (sck_rises - r0 < 5 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("rstm_busy_before", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rstm_cs", 32'(CS), 32'd1);
        chk("rstm_sck", 32'(SCK), 32'd0);
        chk("rstm_copi", 32'(COPI), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        wb_rd_chk("rstm_ctrl", A_CTRL, 32'h0000_0003);
        wb_rd_chk("rstm_stat", A_STAT, 32'h0);

        // Wishbone byte selects, unmapped offsets, range and ack width
        wb_wr("sel_setup", A_CTRL, 32'h0000_0100, 4'b0011);
        wb_wr("sel_byte0", A_CTRL, 32'hFFFF_FFFF, 4'b0001);
        wb_rd_chk("sel_ctrl", A_CTRL, 32'h0000_01FF);
        wb_wr("sel_restore", A_CTRL, 32'h0000_0003, 4'b0011);
        wb_wr("unmapped_wr", BASE + 32'h3, 32'hFFFF_FFFF, 4'hF);
        wb_rd_chk("unmapped_rd", BASE + 32'h6, 32'h0);
        wb_rd_chk("unmapped_ctrl", A_CTRL, 32'h0000_0003);
        wb_xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, r, a);
        chk("out_of_range_noack", 32'(a), 32'd0);

        @(negedge CLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = A_STAT; wbs_sel_i = 4'hF;
        acks = 0; run_a = 0; max_a = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (wbs_ack_o) begin
                acks++;
                run_a++;
                if (run_a > max_a) max_a = run_a;
            end else begin
                run_a = 0;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("held_stb_acks", 32'(acks), 32'd3);
        chk("held_stb_width", 32'(max_a), 32'd1);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rapcore_wb_spi_bridge.md
Name: rapcore_wb_spi_bridge

Overview:
Wishbone slave that lets the management SoC drive the rapcore SPI command port (SCK/CS/COPI/CIPO) on-chip, without the external pads. It sits directly upstream of rapcore in the user-project wrapper. Wishbone is on one side and an SPI master on the other, and the wrapper muxes its outputs against the pad inputs. It performs full-duplex 32-bit SPI mode-0 word transfers, MSB first, with an optional multi-word CS hold.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base; decode compares wbs_adr_i[31:4] against BASE_ADDR[31:4].
DIV_RESET, 8'd3, reset value of CTRL.div.
WORD_BITS, 32, bits per transfer; fixed at 32 for this revision.

Ports:
CLK  in  1  system clock (wb_clk_i in the wrapper)
resetn  in  1  asynchronous, active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte select
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
SCK  out  1  SPI clock to rapcore
CS  out  1  SPI chip select to rapcore, active low
COPI  out  1  SPI data to rapcore
CIPO  in  1  SPI data from rapcore
busy  out  1  transfer in progress (for LA observation)

Behaviour:
- Reset (resetn low, async): SCK=0, CS=1, COPI=0, busy=0, wbs_ack_o=0, wbs_dat_o=0, CTRL.div=DIV_RESET, CTRL.hold=0, RX=0, rx_valid=0, overrun=0, FSM=IDLE. If reset asserts mid-transfer, the transfer is discarded and CS rises immediately.
- Wishbone:
  - valid = cyc & stb & address hit.
  - wbs_ack_o is a registered single-cycle pulse on the cycle after valid; it is never asserted on back-to-back cycles.
  - Read data is registered together with the ack.
  - Hit-range offsets that are unmapped: ack, read 0, writes ignored.
- Register map (offsets):
  - 0x0 CTRL, RW. [7:0] div; [8] hold; [9] abort (write-1 pulse, reads 0). Honours wbs_sel_i per byte.
  - 0x4 STATUS, RO except bit2. [0] busy; [1] rx_valid; [2] overrun (W1C).
  - 0x8 TXDATA, WO. A write while IDLE latches wbs_dat_i (sel ignored) and starts a transfer. A write while busy is acked, dropped, and sets overrun.
  - 0xC RXDATA, RO. Returns the last received word; a read clears rx_valid.
- Timing unit: half-period H = div+1 CLK cycles.
- FSM states: IDLE, SETUP, SHIFT, TRAIL, GAP.
  - IDLE -> SETUP on TXDATA write. busy rises on the same edge as ack. CS=0; COPI=bit31.
  - SETUP: wait H, then -> SHIFT.
  - SHIFT: SCK toggles every H, for 64 half-periods.
    - On each rising SCK edge, sample CIPO into the RX shift register.
    - On each falling SCK edge, present the next TX bit on COPI.
    - After the 32nd falling edge -> TRAIL.
  - TRAIL: wait H with SCK=0. Load RX, set rx_valid (overwriting any unread word), then:
    - if hold=1, go to IDLE with CS kept low;
    - if hold=0, raise CS and -> GAP.
  - GAP: CS high for H, then -> IDLE. busy drops on entry to IDLE.
- Latency: TXDATA ack to busy low = 66·H cycles with hold=0 (264 at div=3); 65·H cycles with hold=1.
- A TXDATA write while IDLE with CS still low (hold chained) skips SETUP and goes straight to SHIFT.
- Clearing hold while IDLE with CS low: CS rises on the next cycle, then GAP.
- Abort (any state): CS=1, SCK=0, COPI=0, -> IDLE on the next edge. rx_valid is unchanged.
- Abort and TXDATA write are on different registers and cannot coincide. A CTRL.div write during a transfer takes effect at the next half-period boundary.
- div=0 is legal: H=1, giving SCK = CLK/2.

Decomposition:
- Package rapcore_wb_spi_pkg holds:
  - register offsets (CTRL/STATUS/TXDATA/RXDATA);
  - CTRL and STATUS bit indices;
  - the FSM state encoding;
  - the DIV_RESET default.
- Sub-module rapcore_spi_shift_engine holds the FSM, half-period counter, bit counter, and TX/RX shifters. It has a start/abort/hold/div/txword in, rxword/done/busy out interface. The top level holds the Wishbone decode and registers.

Test Plan:
- Reset: hold resetn low, release -> CS=1, SCK=0, busy=0; CTRL reads 0x0000_0003; STATUS reads 0.
- Single word: div=3, write TXDATA=0xA5C3_0F96, CIPO model returns 0x1234_5678 -> COPI bits MSB-first match; exactly 32 SCK rising edges; SCK high/low 4 cycles each; busy low 264 cycles after ack; RXDATA=0x1234_5678; rx_valid then clears on read.
- Hold chaining: hold=1, two TXDATA writes -> CS stays low across both words; 64 SCK pulses in total; clear hold -> CS high, held high ≥H cycles.
- Overrun: TXDATA write during busy -> acked; STATUS.overrun=1; COPI stream of the first word unaltered; W1C write clears the bit.
- Abort and reset mid-transfer: abort after 10 SCK pulses -> CS=1 next cycle, busy=0, rx_valid=0. Repeat using resetn asserted asynchronously between CLK edges -> outputs go to reset values before the next edge.
- Wishbone protocol: sel=4'b0001 write 0xFFFF_FFFF to CTRL -> div=0xFF, hold unchanged. Read of offset outside the map -> ack with data 0. Ack is one cycle wide for a held stb.
